bus_arbiter_xbar: RTL and testbench
===================================

Name: bus_arbiter_xbar

Overview:
Parametrised successor to the SoC's single-cycle combinational bus. It connects N_MASTERS masters (ex, if, JTAG, uart, ...) to N_SLAVES slaves, selected by the top SEL_W address bits. It adds a registered arbiter with fixed-priority or round-robin mode, a req/ack handshake with slave wait states, a timeout error response, and per-master stall outputs. It sits between the core/debug masters and the memory/peripheral slaves in the SoC top.

Parameters:
N_MASTERS, 4, number of master channels (2..8)
N_SLAVES, 6, number of slave channels (1..2**SEL_W)
ADDR_W, 32, address width
DATA_W, 32, data width
SEL_W, 4, address MSBs used as slave index
ARB_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
TIMEOUT, 255, cycles waiting for slave ack before error response (>=1)
CNT_W, 8, timeout counter width (2**CNT_W > TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
m_req_i  in  N_MASTERS  per-master request, held until m_ack_o
m_we_i  in  N_MASTERS  per-master write enable
m_addr_i  in  N_MASTERS*ADDR_W  flattened addresses, master i at [i*ADDR_W +: ADDR_W]
m_wdata_i  in  N_MASTERS*DATA_W  flattened write data
m_rdata_o  out  N_MASTERS*DATA_W  registered read data, valid in m_ack_o cycle
m_ack_o  out  N_MASTERS  one-cycle completion pulse
m_err_o  out  N_MASTERS  one-cycle error pulse, coincident with m_ack_o
m_stall_o  out  N_MASTERS  m_req_i[i] & ~m_ack_o[i]; pipeline hold per master
s_req_o  out  N_SLAVES  slave select/request
s_we_o  out  N_SLAVES  slave write enable
s_addr_o  out  N_SLAVES*ADDR_W  slave address, top SEL_W bits forced to 0
s_wdata_o  out  N_SLAVES*DATA_W  slave write data
s_rdata_i  in  N_SLAVES*DATA_W  slave read data, sampled on s_ack_i
s_ack_i  in  N_SLAVES  slave completion; may be asserted in the same cycle as s_req_o
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, grant_q 0, rr pointer 0, timeout counter 0. m_rdata_o, m_ack_o, m_err_o all 0. All slave outputs 0. busy_o 0.
- Unselected slave outputs are always 0. Outputs to unselected masters are 0.
- IDLE: if |m_req_i, compute grant and latch grant_q, then go to BUSY next cycle. Else stay.
- Grant in fixed mode: lowest requesting index.
- Grant in round-robin mode: first requester searching upward from rr_ptr, with wrap-around.
- Slave select: sel_q = m_addr_i[grant][ADDR_W-1 -: SEL_W], latched with grant_q.
- BUSY, mapped slave (sel_q < N_SLAVES):
  - s_req_o[sel_q] = 1; s_we/addr/wdata driven combinationally from the granted master.
  - On s_ack_i[sel_q]: next cycle m_ack_o[g]=1 and m_rdata_o[g] = s_rdata_i[sel_q] (0 for writes). Return to IDLE.
  - In round-robin mode, rr_ptr <= g+1 mod N_MASTERS on completion.
- BUSY, unmapped slave (sel_q >= N_SLAVES): no slave request. Next cycle m_ack_o[g]=1, m_err_o[g]=1, rdata 0. Return to IDLE.
- Timeout: counter increments each BUSY cycle without ack. When it reaches TIMEOUT: ack + err with rdata 0, return to IDLE. The counter clears on entering IDLE.
- Latency: minimum 2 cycles from m_req_i rise to m_ack_o (1 arbitration + 1 registered response) with a zero-wait slave. Each slave wait cycle adds 1.
- Master drops m_req_i[g] while BUSY: abort. Slave outputs drop the same cycle, return to IDLE next cycle, no ack, rr_ptr unchanged.
- The ack cycle always passes through IDLE, so back-to-back grants occur at best every 2 cycles. A new request from the same master in the ack cycle is arbitrated on the following cycle.
- Masters must hold addr/we/wdata stable while requesting. Changes during BUSY are forwarded but sel_q does not change.
- Reset mid-transaction: immediate return to reset values; any pending ack is lost.

Decomposition:
- Shared package/defines file: ARB_FIXED/ARB_RR mode constants, IDLE/BUSY state encodings, ZeroWord width helpers.
- One sub-module: bus_rr_arbiter (req vector, rr_ptr, mode -> one-hot grant plus index). Purely combinational, reusable for a future DMA arbiter.

Test Plan:
- Fixed mode, m0 and m2 request together, slave 1 acks immediately -> m0 gets m_ack_o at cycle 2; m2 acked at cycle 4; m_stall_o[2]=1 during cycles 0-3.
- RR mode, m0..m3 request continuously, all targeting zero-wait slave 0 -> ack order 0,1,2,3,0; each ack 2 cycles apart.
- m1 reads addr 0x2000_0010, slave 2 acks after 3 wait cycles with 0xDEADBEEF -> s_addr_o[2]=0x0000_0010; m_rdata_o[1]=0xDEADBEEF with ack at cycle 5.
- m0 accesses 0x7000_0000 with N_SLAVES=6 -> no s_req_o; m_ack_o[0]=m_err_o[0]=1 at cycle 2.
- Slave never acks, TIMEOUT=4 -> err+ack 4 cycles after BUSY entry; m_rdata_o=0; busy_o then 0.
- rst asserted in BUSY; also m_req_i dropped mid-wait -> all outputs 0 asynchronously; abort yields no ack and the next grant proceeds normally.

Source files
------------

// File: rtl/bus_arbiter_xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_xbar_pkg
// Description : Shared constants and types for the bus arbiter crossbar:
//               arbitration mode codes, FSM state encoding and an index-width
//               helper used to size master/slave index registers.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_xbar_pkg;

    localparam int ARB_FIXED = 0;   // lowest requesting index wins
    localparam int ARB_RR    = 1;   // round-robin, search upward from pointer

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Width of an index into an n-entry vector; never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_arbiter
// Description : Combinational arbiter. Picks one requester from i_req, either
//               the lowest index (fixed mode) or the first one found searching
//               upward from i_rr_ptr with wrap-around (round-robin mode).
// Ports       : i_req        request vector
//               i_rr_ptr     round-robin start index (ignored in fixed mode)
//               i_rr_mode    1 = round-robin, 0 = fixed priority
//               o_grant      one-hot grant
//               o_grant_idx  binary index of the granted requester
//               o_grant_vld  at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    input  logic             i_rr_mode,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_vld
);

    localparam logic [N-1:0] c_one = N'(1);

    int w_pos;

    // Scan offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_pos       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = i_rr_mode ? (int'(i_rr_ptr) + k) % N : k;
            if (|(i_req & (c_one << w_pos))) begin
                o_grant_idx = IDX_W'(w_pos);
                o_grant_vld = 1'b1;
            end
        end
        if (o_grant_vld) begin
            o_grant = c_one << o_grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter_xbar.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_xbar
// Description : N-master to N-slave shared bus with a registered arbiter,
//               req/ack handshake with slave wait states, timeout and
//               unmapped-address error responses, and per-master stalls.
// Ports       : clk, rst          clock, asynchronous active-high reset
//               m_req_i/we/addr/wdata   master requests (flattened vectors)
//               m_rdata_o/ack_o/err_o   registered master responses
//               m_stall_o          master pipeline hold
//               s_req_o/we/addr/wdata   slave requests (only selected slave)
//               s_rdata_i/ack_i    slave responses
//               busy_o             transaction in progress
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_xbar
    import bus_arbiter_xbar_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int N_SLAVES  = 6,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SEL_W     = 4,
    parameter int ARB_MODE  = 0,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req_i,
    input  logic [N_MASTERS-1:0]          m_we_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
    output logic [N_MASTERS-1:0]          m_ack_o,
    output logic [N_MASTERS-1:0]          m_err_o,
    output logic [N_MASTERS-1:0]          m_stall_o,
    output logic [N_SLAVES-1:0]           s_req_o,
    output logic [N_SLAVES-1:0]           s_we_o,
    output logic [N_SLAVES*ADDR_W-1:0]    s_addr_o,
    output logic [N_SLAVES*DATA_W-1:0]    s_wdata_o,
    input  logic [N_SLAVES*DATA_W-1:0]    s_rdata_i,
    input  logic [N_SLAVES-1:0]           s_ack_i,
    output logic                          busy_o
);

    localparam int IDX_W = idx_width(N_MASTERS);
    localparam int LOW_W = ADDR_W - SEL_W;
    localparam logic [N_MASTERS-1:0] c_one = N_MASTERS'(1);

    state_t                   r_state, w_state_nxt;
    logic [IDX_W-1:0]         r_grant, r_rr_ptr;
    logic [SEL_W-1:0]         r_sel;
    logic [CNT_W-1:0]         r_cnt;
    logic [N_MASTERS-1:0]     r_ack, r_err;
    logic [N_MASTERS*DATA_W-1:0] r_rdata;

    logic [N_MASTERS-1:0]     w_arb_req, w_arb_grant;
    logic [IDX_W-1:0]         w_arb_idx;
    logic                     w_arb_vld;
    logic [SEL_W-1:0]         w_new_sel;

    logic                     w_g_req, w_g_we;
    logic [ADDR_W-1:0]        w_g_addr;
    logic [DATA_W-1:0]        w_g_wdata;
    logic                     w_s_ack;
    logic [DATA_W-1:0]        w_s_rdata;
    logic                     w_done, w_err;
    logic [DATA_W-1:0]        w_rd;
    logic [N_MASTERS*DATA_W-1:0] w_rdata_vec;

    // The master being acked still holds its request during the ack cycle;
    // mask it so that request is not re-granted.
    assign w_arb_req = m_req_i & ~r_ack;

    bus_rr_arbiter #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req       (w_arb_req),
        .i_rr_ptr    (r_rr_ptr),
        .i_rr_mode   (ARB_MODE == ARB_RR),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx),
        .o_grant_vld (w_arb_vld)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_rd        = '0;
        w_g_req     = 1'b0;
        w_g_we      = 1'b0;
        w_g_addr    = '0;
        w_g_wdata   = '0;
        w_new_sel   = '0;
        w_s_ack     = 1'b0;
        w_s_rdata   = '0;
        w_rdata_vec = '0;
        s_req_o     = '0;
        s_we_o      = '0;
        s_addr_o    = '0;
        s_wdata_o   = '0;

        for (int i = 0; i < N_MASTERS; i++) begin
            if (int'(r_grant) == i) begin
                w_g_req   = m_req_i[i];
                w_g_we    = m_we_i[i];
                w_g_addr  = m_addr_i[i*ADDR_W +: ADDR_W];
                w_g_wdata = m_wdata_i[i*DATA_W +: DATA_W];
            end
            if (w_arb_grant[i]) begin
                w_new_sel = m_addr_i[i*ADDR_W + ADDR_W - 1 -: SEL_W];
            end
        end

        case (r_state)
            IDLE: begin
                if (w_arb_vld) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!w_g_req) begin
                    // Abort: slave outputs stay 0, no response.
                    w_state_nxt = IDLE;
                end else if (int'(r_sel) >= N_SLAVES) begin
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    for (int j = 0; j < N_SLAVES; j++) begin
                        if (int'(r_sel) == j) begin
                            s_req_o[j]                  = 1'b1;
                            s_we_o[j]                   = w_g_we;
                            s_addr_o[j*ADDR_W +: ADDR_W] = {{SEL_W{1'b0}}, w_g_addr[LOW_W-1:0]};
                            s_wdata_o[j*DATA_W +: DATA_W] = w_g_wdata;
                            w_s_ack                     = s_ack_i[j];
                            w_s_rdata                   = s_rdata_i[j*DATA_W +: DATA_W];
                        end
                    end
                    if (w_s_ack) begin
                        w_done      = 1'b1;
                        w_rd        = w_g_we ? '0 : w_s_rdata;
                        w_state_nxt = IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th cycle without an ack.
                        w_done      = 1'b1;
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        for (int i = 0; i < N_MASTERS; i++) begin
            if (w_done && int'(r_grant) == i) begin
                w_rdata_vec[i*DATA_W +: DATA_W] = w_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_ack    <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_done ? (c_one << r_grant) : '0;
            r_err   <= (w_done && w_err) ? (c_one << r_grant) : '0;
            r_rdata <= w_rdata_vec;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (w_arb_vld) begin
                    r_grant <= w_arb_idx;
                    r_sel   <= w_new_sel;
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_done && ARB_MODE == ARB_RR) begin
                    r_rr_ptr <= (int'(r_grant) == N_MASTERS - 1) ? '0 : r_grant + IDX_W'(1);
                end
            end
        end
    end

    assign m_ack_o   = r_ack;
    assign m_err_o   = r_err;
    assign m_rdata_o = r_rdata;
    assign m_stall_o = m_req_i & ~r_ack;
    assign busy_o    = (r_state == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_xbar.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter_xbar
// Description : Scoreboard bench for bus_arbiter_xbar. One fixed-priority and
//               one round-robin instance (both TIMEOUT=4). Expected acks are
//               queued when stimulus is issued; a monitor pops on every ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_xbar;

    typedef struct {
        int          m;
        int          c;
        logic        e;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   fails = 0;
    int   t0;
    int   wait_f [6];
    int   wc_f [6];
    logic keep_r;
    exp_t q_f [$];
    exp_t q_r [$];

    // fixed-priority instance
    logic [3:0]   m_req_f, m_we_f, m_ack_f, m_err_f, m_stall_f;
    logic [127:0] m_addr_f, m_wdata_f, m_rdata_f;
    logic [5:0]   s_req_f, s_we_f, s_ack_f;
    logic [191:0] s_addr_f, s_wdata_f, s_rdata_f;
    logic         busy_f;
    // round-robin instance
    logic [3:0]   m_req_r, m_we_r, m_ack_r, m_err_r, m_stall_r;
    logic [127:0] m_addr_r, m_wdata_r, m_rdata_r;
    logic [5:0]   s_req_r, s_we_r, s_ack_r;
    logic [191:0] s_addr_r, s_wdata_r, s_rdata_r;
    logic         busy_r;

    bus_arbiter_xbar #(.ARB_MODE(0), .TIMEOUT(4)) u_dut_f (
        .clk(clk), .rst(rst),
        .m_req_i(m_req_f), .m_we_i(m_we_f), .m_addr_i(m_addr_f), .m_wdata_i(m_wdata_f),
        .m_rdata_o(m_rdata_f), .m_ack_o(m_ack_f), .m_err_o(m_err_f), .m_stall_o(m_stall_f),
        .s_req_o(s_req_f), .s_we_o(s_we_f), .s_addr_o(s_addr_f), .s_wdata_o(s_wdata_f),
        .s_rdata_i(s_rdata_f), .s_ack_i(s_ack_f), .busy_o(busy_f)
    );

    bus_arbiter_xbar #(.ARB_MODE(1), .TIMEOUT(4)) u_dut_r (
        .clk(clk), .rst(rst),
        .m_req_i(m_req_r), .m_we_i(m_we_r), .m_addr_i(m_addr_r), .m_wdata_i(m_wdata_r),
        .m_rdata_o(m_rdata_r), .m_ack_o(m_ack_r), .m_err_o(m_err_r), .m_stall_o(m_stall_r),
        .s_req_o(s_req_r), .s_we_o(s_we_r), .s_addr_o(s_addr_r), .s_wdata_o(s_wdata_r),
        .s_rdata_i(s_rdata_r), .s_ack_i(s_ack_r), .busy_o(busy_r)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] slv(input int j);
        return (j == 2) ? 32'hDEAD_BEEF : 32'hA5A5_0000 + 32'(j);
    endfunction

    // Slave models: fixed-instance slaves ack after wait_f[j] wait cycles,
    // round-robin-instance slaves are all zero-wait.
    always @(posedge clk or posedge rst) begin
        for (int j = 0; j < 6; j++) begin
            if (rst) wc_f[j] <= 0;
            else     wc_f[j] <= (s_req_f[j] && !s_ack_f[j]) ? wc_f[j] + 1 : 0;
        end
    end

    always_comb begin
        for (int j = 0; j < 6; j++) begin
            s_ack_f[j]            = s_req_f[j] && (wc_f[j] == wait_f[j]);
            s_rdata_f[j*32 +: 32] = slv(j);
            s_ack_r[j]            = s_req_r[j];
            s_rdata_r[j*32 +: 32] = slv(j);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expect_ack(input int d, input int m, input int c, input logic e, input logic [31:0] rd);
        exp_t x;
        x.m = m; x.c = c; x.e = e; x.rd = rd;
        if (d == 0) q_f.push_back(x);
        else        q_r.push_back(x);
    endtask

    task automatic set_f(input int i, input logic [31:0] a, input logic we, input logic [31:0] wd);
        m_addr_f[i*32 +: 32]  = a;
        m_we_f[i]             = we;
        m_wdata_f[i*32 +: 32] = wd;
    endtask

    // One clock; masters release their request in the cycle they see ack.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (m_ack_f[i]) m_req_f[i] = 1'b0;
            if (m_ack_r[i] && !keep_r) m_req_r[i] = 1'b0;
        end
        #1;
    endtask

    task automatic chk_ack(input int d, input int i, input logic e, input logic [31:0] rd);
        exp_t x;
        vectors++;
        if ((d == 0 && q_f.size() == 0) || (d == 1 && q_r.size() == 0)) begin
            fails++;
            $display("FAIL ack_unexpected dut%0d: master %0d acked at cycle %0d, none expected", d, i, cyc);
            return;
        end
        if (d == 0) x = q_f.pop_front();
        else        x = q_r.pop_front();
        if (x.m != i || x.c != cyc || x.e !== e || x.rd !== rd) begin
            fails++;
            $display("FAIL ack dut%0d: got m%0d cyc %0d err %0b rdata 0x%08h, expected m%0d cyc %0d err %0b rdata 0x%08h",
                     d, i, cyc, e, rd, x.m, x.c, x.e, x.rd);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (m_ack_f[i]) chk_ack(0, i, m_err_f[i], m_rdata_f[i*32 +: 32]);
                else if (m_err_f[i]) begin
                    vectors++; fails++;
                    $display("FAIL err_without_ack dut0: master %0d at cycle %0d", i, cyc);
                end
                if (m_ack_r[i]) chk_ack(1, i, m_err_r[i], m_rdata_r[i*32 +: 32]);
                else if (m_err_r[i]) begin
                    vectors++; fails++;
                    $display("FAIL err_without_ack dut1: master %0d at cycle %0d", i, cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; keep_r = 1'b0;
        m_req_f = '0; m_we_f = '0; m_addr_f = '0; m_wdata_f = '0;
        m_req_r = '0; m_we_r = '0; m_addr_r = '0; m_wdata_r = '0;
        for (int j = 0; j < 6; j++) wait_f[j] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_f), 0);
        check("rst_sreq", 32'(s_req_f), 0);
        check("rst_ack", 32'(m_ack_f | m_ack_r), 0);
        check("rst_rdata", m_rdata_f[31:0] | m_rdata_r[31:0], 0);
        rst = 1'b0;
        tick();

        // Fixed priority: m0 and m2 together to zero-wait slave 1.
        set_f(0, 32'h1000_0000, 1'b0, 32'h0);
        set_f(2, 32'h1000_0004, 1'b0, 32'h0);
        m_req_f = 4'b0101; t0 = cyc;
        expect_ack(0, 0, t0 + 2, 1'b0, slv(1));
        expect_ack(0, 2, t0 + 4, 1'b0, slv(1));
        for (int k = 0; k < 6; k++) begin
            #1;
            check("fix_stall2", 32'(m_stall_f[2]), 32'(k < 4));
            tick();
        end

        // Round robin: all four masters continuously to zero-wait slave 0.
        for (int i = 0; i < 4; i++) m_addr_r[i*32 +: 32] = 32'h0000_0000 + 32'(i * 4);
        keep_r = 1'b1; m_req_r = 4'hF; t0 = cyc;
        expect_ack(1, 0, t0 + 2, 1'b0, slv(0));
        expect_ack(1, 1, t0 + 4, 1'b0, slv(0));
        expect_ack(1, 2, t0 + 6, 1'b0, slv(0));
        expect_ack(1, 3, t0 + 8, 1'b0, slv(0));
        expect_ack(1, 0, t0 + 10, 1'b0, slv(0));
        repeat (10) tick();
        m_req_r = '0; keep_r = 1'b0;
        tick();
        check("rr_idle_after", 32'(busy_r), 0);
        tick();

        // Read with 3 wait states from slave 2.
        set_f(1, 32'h2000_0010, 1'b0, 32'h0);
        wait_f[2] = 3; m_req_f[1] = 1'b1; t0 = cyc;
        expect_ack(0, 1, t0 + 5, 1'b0, 32'hDEAD_BEEF);
        tick();
        check("rd_sreq", 32'(s_req_f), 32'h04);
        check("rd_saddr", s_addr_f[2*32 +: 32], 32'h0000_0010);
        check("rd_swe", 32'(s_we_f), 0);
        repeat (5) tick();

        // Write with 1 wait state to slave 3: rdata returns 0.
        set_f(3, 32'h3000_0008, 1'b1, 32'hCAFE_F00D);
        wait_f[3] = 1; m_req_f[3] = 1'b1; t0 = cyc;
        expect_ack(0, 3, t0 + 3, 1'b0, 32'h0);
        tick();
        check("wr_swe", 32'(s_we_f), 32'h08);
        check("wr_swdata", s_wdata_f[3*32 +: 32], 32'hCAFE_F00D);
        check("wr_saddr", s_addr_f[3*32 +: 32], 32'h0000_0008);
        repeat (3) tick();

        // Unmapped slave 7: error response, no slave request.
        set_f(0, 32'h7000_0000, 1'b0, 32'h0);
        m_req_f[0] = 1'b1; t0 = cyc;
        expect_ack(0, 0, t0 + 2, 1'b1, 32'h0);
        tick();
        check("unmap_sreq", 32'(s_req_f), 0);
        check("unmap_busy", 32'(busy_f), 1);
        repeat (2) tick();

        // Highest mapped slave 5.
        set_f(2, 32'h5000_0000, 1'b0, 32'h0);
        m_req_f[2] = 1'b1; t0 = cyc;
        expect_ack(0, 2, t0 + 2, 1'b0, slv(5));
        tick();
        check("sel5_sreq", 32'(s_req_f), 32'h20);
        repeat (2) tick();

        // Timeout: slave 4 never acks.
        set_f(1, 32'h4000_0000, 1'b0, 32'h0);
        wait_f[4] = 1000; m_req_f[1] = 1'b1; t0 = cyc;
        expect_ack(0, 1, t0 + 5, 1'b1, 32'h0);
        repeat (4) tick();
        check("to_busy", 32'(busy_f), 1);
        tick();
        check("to_idle", 32'(busy_f), 0);
        tick();

        // Abort: master drops its request while the slave waits.
        set_f(2, 32'h1000_0000, 1'b0, 32'h0);
        wait_f[1] = 1000; m_req_f[2] = 1'b1;
        repeat (2) tick();
        check("abort_sreq_on", 32'(s_req_f), 32'h02);
        m_req_f[2] = 1'b0;
        #1;
        check("abort_sreq_off", 32'(s_req_f), 0);
        tick();
        check("abort_idle", 32'(busy_f), 0);
        set_f(3, 32'h0000_0000, 1'b0, 32'h0);
        m_req_f[3] = 1'b1; t0 = cyc;
        expect_ack(0, 3, t0 + 2, 1'b0, slv(0));
        repeat (3) tick();

        // Asynchronous reset in BUSY.
        set_f(0, 32'h1000_0000, 1'b0, 32'h0);
        m_req_f[0] = 1'b1;
        repeat (2) tick();
        check("prerst_busy", 32'(busy_f), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy_f), 0);
        check("rst_mid_sreq", 32'(s_req_f), 0);
        m_req_f = '0;
        tick();
        rst = 1'b0;
        set_f(1, 32'h0000_0004, 1'b0, 32'h0);
        m_req_f[1] = 1'b1; t0 = cyc;
        expect_ack(0, 1, t0 + 2, 1'b0, slv(0));
        repeat (4) tick();

        check("pending_f", 32'(q_f.size()), 0);
        check("pending_r", 32'(q_r.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
